// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - master and memory side signals of the two-port data memory arbiter
interface dmem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          req0;
    logic          req1;
    logic          lock0;
    logic          lock1;
    logic          we0;
    logic          we1;
    logic [AW-1:0] addr0;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wdata0;
    logic [DW-1:0] wdata1;
    logic          gnt0;
    logic          gnt1;
    logic          rvalid0;
    logic          rvalid1;
    logic [DW-1:0] rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic [DW-1:0] mem_rdata;

    // Arbiter view: requests and memory read data in, grants and memory pins out.
    modport slave (
        input  req0, req1, lock0, lock1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
        output gnt0, gnt1, rvalid0, rvalid1, rdata, mem_addr, mem_wdata, mem_we
    );

    // Environment view: the two masters plus the memory itself.
    modport master (
        output req0, req1, lock0, lock1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata, mem_addr, mem_wdata, mem_we
    );
endinterface

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - round-robin arbiter sharing one data memory between two masters
module dmem_arbiter #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int MAX_HOLD = 4
) (
    input  logic           clk,
    input  logic           rst,
    dmem_arbiter_if.slave  bus
);
    localparam int              HW       = $clog2(MAX_HOLD) + 1;
    localparam logic [HW-1:0]   HOLD_LIM = HW'(MAX_HOLD - 1);

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_OWN0 = 2'b01;
    localparam logic [1:0] S_OWN1 = 2'b10;

    logic [1:0]    state;
    logic [1:0]    state_n;
    logic          last;
    logic          last_n;
    logic [HW-1:0] hold_cnt;
    logic [HW-1:0] hold_n;
    logic [DW-1:0] rdata_q;
    logic          rvalid0_q;
    logic          rvalid1_q;
    logic          xfer0;
    logic          xfer1;
    logic          rd0;
    logic          rd1;

    // Grants come from the owner state alone so they never depend on this cycle's req.
    assign bus.gnt0    = (state == S_OWN0);
    assign bus.gnt1    = (state == S_OWN1);
    assign xfer0       = bus.gnt0 & bus.req0;
    assign xfer1       = bus.gnt1 & bus.req1;
    assign rd0         = xfer0 & ~bus.we0;
    assign rd1         = xfer1 & ~bus.we1;
    assign bus.rdata   = rdata_q;
    assign bus.rvalid0 = rvalid0_q;
    assign bus.rvalid1 = rvalid1_q;

    // Memory pins follow the transferring port; idle slots drive zeros so nothing is written.
    always_comb begin
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_we    = 1'b0;
        if (xfer0) begin
            bus.mem_addr  = bus.addr0;
            bus.mem_wdata = bus.wdata0;
            bus.mem_we    = bus.we0;
        end else if (xfer1) begin
            bus.mem_addr  = bus.addr1;
            bus.mem_wdata = bus.wdata1;
            bus.mem_we    = bus.we1;
        end
    end

    // Owner selection: locked owner keeps the memory for a bounded run, otherwise hand over on contention.
    always_comb begin
        state_n = state;
        last_n  = last;
        hold_n  = '0;
        case (state)
            S_IDLE: begin
                if (bus.req0 && bus.req1) state_n = last ? S_OWN0 : S_OWN1;
                else if (bus.req0)        state_n = S_OWN0;
                else if (bus.req1)        state_n = S_OWN1;
            end
            S_OWN0: begin
                if (bus.req0 && bus.lock0 && (hold_cnt < HOLD_LIM)) begin
                    hold_n = hold_cnt + 1'b1;
                end else if (bus.req1) begin
                    state_n = S_OWN1;
                    last_n  = 1'b0;
                end else if (!bus.req0) begin
                    state_n = S_IDLE;
                    last_n  = 1'b0;
                end
            end
            S_OWN1: begin
                if (bus.req1 && bus.lock1 && (hold_cnt < HOLD_LIM)) begin
                    hold_n = hold_cnt + 1'b1;
                end else if (bus.req0) begin
                    state_n = S_OWN0;
                    last_n  = 1'b1;
                end else if (!bus.req1) begin
                    state_n = S_IDLE;
                    last_n  = 1'b1;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Owner state register; last=1 at reset so port 0 wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            last     <= 1'b1;
            hold_cnt <= '0;
        end else begin
            state    <= state_n;
            last     <= last_n;
            hold_cnt <= hold_n;
        end
    end

    // Read return pipeline: capture memory data at the close of a read transfer and pulse that port's valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q   <= '0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
        end else begin
            rvalid0_q <= rd0;
            rvalid1_q <= rd1;
            if (rd0 || rd1) rdata_q <= bus.mem_rdata;
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter with a behavioural reference model
module tb_dmem_arbiter;
    localparam int AW       = 32;
    localparam int DW       = 32;
    localparam int MAX_HOLD = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.AW(AW), .DW(DW)) bus ();
    dmem_arbiter #(.AW(AW), .DW(DW), .MAX_HOLD(MAX_HOLD)) dut (.clk(clk), .rst(rst), .bus(bus));

    logic [31:0] mem    [0:63];
    logic [31:0] golden [0:63];

    assign bus.mem_rdata = mem[bus.mem_addr[5:0]];
    always @(posedge clk) if (bus.mem_we) mem[bus.mem_addr[5:0]] <= bus.mem_wdata;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: who owns the memory, who was served last, how long the locked run has been.
    int          m_owner;
    int          m_last;
    int          m_streak;
    int          mo;
    int          mj;
    logic [31:0] ma;
    logic [31:0] m_rdata;
    bit          m_rv0;
    bit          m_rv1;
    bit          model_on = 1'b0;

    function automatic bit preq(input int p);   return (p == 0) ? bus.req0  : bus.req1;  endfunction
    function automatic bit plock(input int p);  return (p == 0) ? bus.lock0 : bus.lock1; endfunction
    function automatic bit pwe(input int p);    return (p == 0) ? bus.we0   : bus.we1;   endfunction
    function automatic logic [31:0] paddr(input int p);  return (p == 0) ? bus.addr0  : bus.addr1;  endfunction
    function automatic logic [31:0] pwdata(input int p); return (p == 0) ? bus.wdata0 : bus.wdata1; endfunction

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_owner  = -1;
            m_last   = 1;
            m_streak = 0;
            m_rdata  = '0;
            m_rv0    = 1'b0;
            m_rv1    = 1'b0;
            model_on = 1'b1;
        end else if (model_on) begin
            m_rv0 = 1'b0;
            m_rv1 = 1'b0;
            if (m_owner >= 0 && preq(m_owner)) begin
                ma = paddr(m_owner);
                if (pwe(m_owner)) golden[ma[5:0]] = pwdata(m_owner);
                else begin
                    m_rdata = golden[ma[5:0]];
                    if (m_owner == 0) m_rv0 = 1'b1; else m_rv1 = 1'b1;
                end
            end
            if (m_owner < 0) begin
                if (bus.req0 && bus.req1) m_owner = 1 - m_last;
                else if (bus.req0)        m_owner = 0;
                else if (bus.req1)        m_owner = 1;
                m_streak = 0;
            end else begin
                mo = m_owner;
                mj = 1 - mo;
                if (preq(mo) && plock(mo) && (m_streak + 1 < MAX_HOLD)) m_streak++;
                else if (preq(mj)) begin m_owner = mj; m_last = mo; m_streak = 0; end
                else if (preq(mo)) m_streak = 0;
                else begin m_owner = -1; m_last = mo; m_streak = 0; end
            end
        end
    end

    // Every-cycle comparison of all outputs against the model, mid-cycle.
    bit          e_x0;
    bit          e_x1;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    bit          e_we;
    initial forever begin
        @(negedge clk);
        if (model_on) begin
            e_x0    = (m_owner == 0) && bus.req0;
            e_x1    = (m_owner == 1) && bus.req1;
            e_addr  = e_x0 ? bus.addr0  : e_x1 ? bus.addr1  : 32'd0;
            e_wdata = e_x0 ? bus.wdata0 : e_x1 ? bus.wdata1 : 32'd0;
            e_we    = e_x0 ? bus.we0    : e_x1 ? bus.we1    : 1'b0;
            chk("m_gnt0",      32'(bus.gnt0),    32'(m_owner == 0));
            chk("m_gnt1",      32'(bus.gnt1),    32'(m_owner == 1));
            chk("m_mem_we",    32'(bus.mem_we),  32'(e_we));
            chk("m_mem_addr",  bus.mem_addr,     e_addr);
            chk("m_mem_wdata", bus.mem_wdata,    e_wdata);
            chk("m_rvalid0",   32'(bus.rvalid0), 32'(m_rv0));
            chk("m_rvalid1",   32'(bus.rvalid1), 32'(m_rv1));
            chk("m_rdata",     bus.rdata,        m_rdata);
        end
    end

    task automatic idle_inputs();
        bus.req0 = 0; bus.req1 = 0; bus.lock0 = 0; bus.lock1 = 0;
        bus.we0 = 0; bus.we1 = 0; bus.addr0 = '0; bus.addr1 = '0;
        bus.wdata0 = '0; bus.wdata1 = '0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        idle_inputs();
        repeat (2) cyc();
        rst = 1'b0;
    endtask

    int  n0;
    int  n1;
    int  cnt1;
    bit  t0;
    bit  t1;
    bit  rv1_seen;
    bit  g0 [0:20];
    bit  g1 [0:20];

    initial begin
        rst = 1'b0;
        idle_inputs();
        for (int i = 0; i < 64; i++) begin
            mem[i]    = 32'hA500_0000 | 32'(i);
            golden[i] = 32'hA500_0000 | 32'(i);
        end
        #1 rst = 1'b1;
        repeat (2) cyc();
        rst = 1'b0;
        #3;
        chk("rst_gnt0", 32'(bus.gnt0), 0);
        chk("rst_gnt1", 32'(bus.gnt1), 0);
        chk("rst_rvalid0", 32'(bus.rvalid0), 0);
        chk("rst_rdata", bus.rdata, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);

        // Single read on port 0
        do_reset();
        mem[44] = 32'h30; golden[44] = 32'h30;
        cyc(); bus.req0 = 1; bus.addr0 = 44; #3 chk("rd_c1_gnt0", 32'(bus.gnt0), 0);
        cyc(); #3;
        chk("rd_c2_gnt0", 32'(bus.gnt0), 1);
        chk("rd_c2_addr", bus.mem_addr, 44);
        chk("rd_c2_we", 32'(bus.mem_we), 0);
        cyc(); bus.req0 = 0; #3;
        chk("rd_c3_rvalid0", 32'(bus.rvalid0), 1);
        chk("rd_c3_rdata", bus.rdata, 32'h30);
        cyc(); #3;
        chk("rd_c4_gnt0", 32'(bus.gnt0), 0);
        chk("rd_c4_rvalid0", 32'(bus.rvalid0), 0);

        // Tie after reset: alternate starting with port 0
        do_reset();
        n0 = 0; n1 = 0;
        cyc(); bus.req0 = 1; bus.req1 = 1; bus.addr0 = 1; bus.addr1 = 2;
        for (int k = 0; k < 4; k++) begin
            cyc(); #3;
            chk("tie_gnt0", 32'(bus.gnt0), 32'((k % 2) == 0));
            chk("tie_gnt1", 32'(bus.gnt1), 32'((k % 2) == 1));
            n0 += int'(bus.rvalid0); n1 += int'(bus.rvalid1);
        end
        cyc(); bus.req0 = 0; bus.req1 = 0; #3;
        n0 += int'(bus.rvalid0); n1 += int'(bus.rvalid1);
        chk("tie_n0", n0, 2);
        chk("tie_n1", n1, 2);
        cyc();

        // Locked burst on port 1, port 0 requests on the 2nd burst cycle
        do_reset();
        cnt1 = 0; t0 = 0; t1 = 0;
        cyc(); bus.req1 = 1; bus.lock1 = 1; bus.addr1 = 8;
        #3 t1 = bus.gnt1 & bus.req1;
        for (int c = 2; c <= 20; c++) begin
            cyc();
            if (t1) cnt1++;
            if (cnt1 >= 8) begin bus.req1 = 0; bus.lock1 = 0; end
            else bus.addr1 = 32'(8 + cnt1);
            if (c == 3) begin bus.req0 = 1; bus.addr0 = 3; end
            if (t0) bus.req0 = 0;
            #3;
            g0[c] = bus.gnt0; g1[c] = bus.gnt1;
            t0 = bus.gnt0 & bus.req0;
            t1 = bus.gnt1 & bus.req1;
        end
        for (int c = 2; c <= 5; c++) chk("burst_hold_gnt1", 32'(g1[c]), 1);
        chk("burst_gnt0_c6", 32'(g0[6]), 1);
        chk("burst_resume_c7", 32'(g1[7]), 1);
        chk("burst_count", cnt1, 8);
        idle_inputs();

        // Port 1 writes, port 0 reads the same word
        do_reset();
        rv1_seen = 0;
        cyc(); bus.req1 = 1; bus.we1 = 1; bus.addr1 = 56; bus.wdata1 = 32'hDEADBEEF;
        cyc(); #3;
        chk("wr_gnt1", 32'(bus.gnt1), 1);
        chk("wr_mem_we", 32'(bus.mem_we), 1);
        chk("wr_mem_addr", bus.mem_addr, 56);
        chk("wr_mem_wdata", bus.mem_wdata, 32'hDEADBEEF);
        cyc(); bus.req1 = 0; bus.we1 = 0; bus.req0 = 1; bus.addr0 = 56; #3 rv1_seen |= bus.rvalid1;
        cyc(); #3 chk("wr_rd_gnt0", 32'(bus.gnt0), 1); rv1_seen |= bus.rvalid1;
        cyc(); bus.req0 = 0; #3;
        chk("wr_rd_rvalid0", 32'(bus.rvalid0), 1);
        chk("wr_rd_rdata", bus.rdata, 32'hDEADBEEF);
        rv1_seen |= bus.rvalid1;
        cyc(); #3 rv1_seen |= bus.rvalid1;
        chk("wr_no_rvalid1", 32'(rv1_seen), 0);

        // Idle slot: request dropped before its grant cycle
        do_reset();
        cyc(); bus.req0 = 1; bus.we0 = 1; bus.addr0 = 5; bus.wdata0 = 32'h55;
        cyc(); bus.req0 = 0; #3;
        chk("idle_gnt0", 32'(bus.gnt0), 1);
        chk("idle_mem_we", 32'(bus.mem_we), 0);
        cyc(); #3;
        chk("idle_after_gnt0", 32'(bus.gnt0), 0);
        chk("idle_rvalid0", 32'(bus.rvalid0), 0);
        chk("idle_mem5", mem[5], 32'hA500_0005);
        idle_inputs();

        // Asynchronous reset in the middle of a write transfer
        do_reset();
        cyc(); bus.req0 = 1; bus.we0 = 1; bus.addr0 = 20; bus.wdata0 = 32'h1234_5678;
        cyc(); #1;
        chk("ar_pre_gnt0", 32'(bus.gnt0), 1);
        chk("ar_pre_we", 32'(bus.mem_we), 1);
        #1 rst = 1'b1;
        #1;
        chk("ar_gnt0", 32'(bus.gnt0), 0);
        chk("ar_mem_we", 32'(bus.mem_we), 0);
        chk("ar_mem_addr", bus.mem_addr, 0);
        chk("ar_rdata", bus.rdata, 0);
        cyc();
        chk("ar_mem20", mem[20], 32'hA500_0014);
        idle_inputs();
        rst = 1'b0;
        cyc(); #3;
        chk("ar_post_gnt0", 32'(bus.gnt0), 0);
        chk("ar_post_rvalid0", 32'(bus.rvalid0), 0);

        // Randomized traffic; requesters hold their transfer stable until granted
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            cyc();
            if (!(bus.req0 && !bus.gnt0)) begin
                bus.req0   = ($urandom_range(0, 99) < 60);
                bus.we0    = $urandom_range(0, 1) == 1;
                bus.addr0  = 32'($urandom_range(0, 63));
                bus.wdata0 = $urandom;
            end
            if (!(bus.req1 && !bus.gnt1)) begin
                bus.req1   = ($urandom_range(0, 99) < 60);
                bus.we1    = $urandom_range(0, 1) == 1;
                bus.addr1  = 32'($urandom_range(0, 63));
                bus.wdata1 = $urandom;
            end
            bus.lock0 = ($urandom_range(0, 3) == 0);
            bus.lock1 = ($urandom_range(0, 3) == 0);
        end
        idle_inputs();
        repeat (3) cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
